ifetch_stage: RTL

IFETCH_STAGE -- requirements
Module: ifetch_stage

---
 rtl/ifetch_stage.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: one outstanding memory request, hold buffer, redirect handling.
// Optional misaligned-fetch trap enabled by defining IF_ADEL_CHECK_EN.
module ifetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_stall_i,
    input  logic        if_flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        id_branch_en_i,
    input  logic [31:0] id_branch_pc_i,
    input  logic        id_next_inslot_i,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_addr_ok_i,
    input  logic        inst_data_ok_i,
    input  logic [31:0] inst_rdata_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_inslot_o,
    output logic        id_valid_o,
    output logic        if_stallreq_o,
    output logic        id_excadel_o
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        CANCEL
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] issued_pc;
    logic [31:0] pend_pc;
    logic        pend_valid;
    logic        slot_flag;
    logic [31:0] hold_pc;
    logic [31:0] hold_inst;
    logic        halted;
    logic        excadel;

    logic        misaligned;
    logic        req_live;
    logic        branch_take;
    logic        pend_eff;
    logic [31:0] target_eff;
    logic        slot_eff;
    logic        deliver_mem;
    logic        deliver_hold;
    logic        deliver_adel;
    logic        deliver;

`ifdef IF_ADEL_CHECK_EN
    assign misaligned = (fetch_pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign req_live    = (state == REQ) && !misaligned;
    assign inst_req_o  = req_live;
    assign inst_addr_o = req_live ? fetch_pc : 32'h0;

    // Branches are ignored while cancelling so the stored redirect wins.
    assign branch_take = id_branch_en_i && !if_stall_i
                         && !if_flush_i && (state != CANCEL);
    assign pend_eff    = pend_valid || branch_take;
    assign target_eff  = branch_take ? id_branch_pc_i : pend_pc;
    assign slot_eff    = slot_flag || (id_next_inslot_i && !if_stall_i);

    assign deliver_mem  = (state == WAIT) && inst_data_ok_i
                          && !if_stall_i && !if_flush_i;
    assign deliver_hold = (state == HOLD) && !if_stall_i && !if_flush_i;
    assign deliver_adel = (state == REQ) && misaligned
                          && !if_stall_i && !if_flush_i;
    assign deliver      = deliver_mem || deliver_hold || deliver_adel;

    assign if_stallreq_o = ((state == REQ) || (state == WAIT)
                            || (state == CANCEL)) && !deliver;

`ifdef IF_ADEL_CHECK_EN
    assign id_excadel_o = excadel;
`else
    assign id_excadel_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            issued_pc   <= 32'h0;
            pend_pc     <= 32'h0;
            pend_valid  <= 1'b0;
            slot_flag   <= 1'b0;
            hold_pc     <= 32'h0;
            hold_inst   <= 32'h0;
            halted      <= 1'b0;
            excadel     <= 1'b0;
            id_pc_o     <= 32'h0;
            id_inst_o   <= 32'h0;
            id_inslot_o <= 1'b0;
            id_valid_o  <= 1'b0;
        end else begin
            if (if_flush_i || (!if_stall_i && !deliver)) begin
                id_pc_o     <= 32'h0;
                id_inst_o   <= 32'h0;
                id_inslot_o <= 1'b0;
                id_valid_o  <= 1'b0;
                excadel     <= 1'b0;
            end else if (deliver_mem) begin
                id_pc_o     <= issued_pc;
                id_inst_o   <= inst_rdata_i;
                id_inslot_o <= slot_eff;
                id_valid_o  <= 1'b1;
                excadel     <= 1'b0;
            end else if (deliver_hold) begin
                id_pc_o     <= hold_pc;
                id_inst_o   <= hold_inst;
                id_inslot_o <= slot_eff;
                id_valid_o  <= 1'b1;
                excadel     <= 1'b0;
            end else if (deliver_adel) begin
                id_pc_o     <= fetch_pc;
                id_inst_o   <= 32'h0;
                id_inslot_o <= slot_eff;
                id_valid_o  <= 1'b1;
                excadel     <= 1'b1;
            end

            if (if_flush_i) begin
                slot_flag  <= 1'b0;
                pend_valid <= 1'b0;
            end else begin
                if (deliver) begin
                    slot_flag <= 1'b0;
                end else if (id_next_inslot_i && !if_stall_i) begin
                    slot_flag <= 1'b1;
                end
                if (branch_take) begin
                    pend_valid <= 1'b1;
                    pend_pc    <= id_branch_pc_i;
                end
            end

            unique case (state)
                IDLE: begin
                    if (if_flush_i) begin
                        fetch_pc <= flush_pc_i;
                        halted   <= 1'b0;
                        state    <= REQ;
                    end else if (!halted) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (if_flush_i) begin
                        fetch_pc <= flush_pc_i;
                        if (req_live && inst_addr_ok_i) begin
                            state <= CANCEL;
                        end
                    end else if (misaligned) begin
                        if (!if_stall_i) begin
                            halted <= 1'b1;
                            state  <= IDLE;
                        end
                    end else if (inst_addr_ok_i) begin
                        issued_pc <= fetch_pc;
                        fetch_pc  <= fetch_pc + 32'd4;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (if_flush_i) begin
                        fetch_pc <= flush_pc_i;
                        state    <= inst_data_ok_i ? REQ : CANCEL;
                    end else if (inst_data_ok_i) begin
                        if (if_stall_i) begin
                            hold_pc   <= issued_pc;
                            hold_inst <= inst_rdata_i;
                            state     <= HOLD;
                        end else begin
                            if (pend_eff) begin
                                fetch_pc <= target_eff;
                            end
                            pend_valid <= 1'b0;
                            state      <= REQ;
                        end
                    end
                end
                HOLD: begin
                    if (if_flush_i) begin
                        fetch_pc  <= flush_pc_i;
                        hold_pc   <= 32'h0;
                        hold_inst <= 32'h0;
                        state     <= REQ;
                    end else if (!if_stall_i) begin
                        if (pend_eff) begin
                            fetch_pc <= target_eff;
                        end
                        pend_valid <= 1'b0;
                        state      <= REQ;
                    end
                end
                CANCEL: begin
                    if (if_flush_i) begin
                        fetch_pc <= flush_pc_i;
                    end
                    if (inst_data_ok_i) begin
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
